// File: rtl/bp_update_queue_if.sv
// Branch-predictor update queue bus.
//   slave  : the queue (consumes in_*, pause, flush; drives ready, issue port, stats)
//   master : the resolution side / environment driving the queue
interface bp_update_queue_if #(
  parameter int NUM_REQ = 2,
  parameter int PKT_W   = 26,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*PKT_W-1:0] in_pkt;
  logic [NUM_REQ-1:0]       in_taken;
  logic [NUM_REQ-1:0]       in_mispred;
  logic                     in_ready;
  logic                     pause;
  logic                     flush;
  logic                     out_valid;
  logic [PKT_W-1:0]         out_pkt;
  logic                     out_taken;
  logic                     out_mispred;
  logic                     busy;
  logic [CNT_W-1:0]         stat_updates;
  logic [CNT_W-1:0]         stat_mispreds;
  logic [CNT_W-1:0]         stat_full_cycles;

  modport slave (
    input  in_valid, in_pkt, in_taken, in_mispred, pause, flush,
    output in_ready, out_valid, out_pkt, out_taken, out_mispred, busy,
           stat_updates, stat_mispreds, stat_full_cycles
  );

  modport master (
    output in_valid, in_pkt, in_taken, in_mispred, pause, flush,
    input  in_ready, out_valid, out_pkt, out_taken, out_mispred, busy,
           stat_updates, stat_mispreds, stat_full_cycles
  );
endinterface

// File: rtl/bp_update_queue.sv
// Branch-predictor update queue.
// Gathers up to NUM_REQ resolved-branch updates per cycle into an in-order
// circular FIFO and issues one per cycle to the predictor's update port.
// Ports:
//   clock_i  : clock
//   reset_i  : synchronous active-low reset
//   q        : bp_update_queue_if.slave (inputs, issue port, pause/flush, stats)
module bp_update_queue #(
  parameter int NUM_REQ      = 2,
  parameter int DEPTH        = 8,
  parameter int HISTORY_BITS = 8,
  parameter int PKT_W        = 3*HISTORY_BITS+2,
  parameter int CNT_W        = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  bp_update_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN = 2'd0, PAUSED = 2'd1, FLUSH = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic [PW-1:0]               head_q, tail_q;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0][PKT_W-1:0] pkt_q;
  logic [DEPTH-1:0]            taken_q, mis_q;
  logic [CNT_W-1:0]            upd_q, misp_q, full_q;

  logic                        ready, accept, pop, full_evt;
  logic [CW-1:0]               n_acc, n_push;
  logic [NUM_REQ-1:0][PW-1:0]  wr_idx;

  // Ready only looks at the registered count; a pop in the same cycle is
  // not credited, so the check is a plain threshold.
  assign ready    = (state_q != FLUSH) && (count_q <= CW'(DEPTH - NUM_REQ));
  assign accept   = ready && !q.flush;
  // The predictor consumes every cycle, so issuing is the same as popping.
  assign pop      = (state_q == RUN) && (count_q != '0) && !q.pause && !q.flush;
  assign full_evt = !ready && (|q.in_valid);

  // Compact the valid sources into consecutive slots starting at tail.
  always_comb begin
    n_acc  = '0;
    wr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_idx[i] = tail_q + n_acc[PW-1:0];
      if (q.in_valid[i]) n_acc = n_acc + 1'b1;
    end
    n_push  = accept ? n_acc : '0;
    count_d = count_q + n_push - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    if (q.flush) state_d = FLUSH;
    else         state_d = q.pause ? PAUSED : RUN;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      upd_q   <= '0;
      misp_q  <= '0;
      full_q  <= '0;
    end else begin
      state_q <= state_d;
      if (q.flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PW'(pop);
        tail_q  <= tail_q + n_push[PW-1:0];
        count_q <= count_d;
      end
      // Statistics saturate and survive flush.
      if (pop && upd_q != '1)                       upd_q  <= upd_q + 1'b1;
      if (pop && mis_q[head_q] && misp_q != '1)     misp_q <= misp_q + 1'b1;
      if (full_evt && full_q != '1)                 full_q <= full_q + 1'b1;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && q.in_valid[i]) begin
        pkt_q[wr_idx[i]]   <= q.in_pkt[i*PKT_W +: PKT_W];
        taken_q[wr_idx[i]] <= q.in_taken[i];
        mis_q[wr_idx[i]]   <= q.in_mispred[i];
      end
    end
  end

  assign q.in_ready         = ready;
  assign q.out_valid        = pop;
  assign q.out_pkt          = pop ? pkt_q[head_q] : '0;
  assign q.out_taken        = pop & taken_q[head_q];
  assign q.out_mispred      = pop & mis_q[head_q];
  assign q.busy             = (count_q != '0);
  assign q.stat_updates     = upd_q;
  assign q.stat_mispreds    = misp_q;
  assign q.stat_full_cycles = full_q;
endmodule
